morse_encoder: RTL and testbench

MORSE_ENCODER -- requirements
Module: morse_encoder

---
 rtl/morse_pkg.sv | 33 +++
 rtl/morse_code_rom.sv | 58 +++++
 rtl/morse_encoder.sv | 126 ++++++++++++
 tb/tb_morse_encoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse types and timing multipliers for the encoder and decoder.
package morse_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MARK,
      S_GAP,
      S_CHAR_GAP,
      S_WORD_GAP
   } state_t;

   localparam int unsigned DOT_UNITS      = 1;
   localparam int unsigned DASH_UNITS     = 3;
   localparam int unsigned ELEM_GAP_UNITS = 1;
   localparam int unsigned CHAR_GAP_UNITS = 3;
   localparam int unsigned WORD_GAP_UNITS = 4;

   // pat is sent MSB-first from bit[len-1]; 1 = dash, 0 = dot.
   typedef struct packed {
      logic [2:0] len;
      logic [4:0] pat;
      logic       valid;
   } code_t;

   function automatic code_t mk_code(input logic [2:0] len, input logic [4:0] pat);
      code_t c;
      c.len   = len;
      c.pat   = pat;
      c.valid = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/morse_code_rom.sv
// Combinational ASCII-to-Morse lookup with lower-case folding.
module morse_code_rom
   import morse_pkg::*;
(
   input  logic [7:0] i_char,
   output code_t      o_code
);

   logic [7:0] w_upper;

   always_comb begin
      w_upper = i_char;
      if (i_char >= 8'h61 && i_char <= 8'h7A) w_upper = i_char - 8'h20;
      o_code = '0;
      case (w_upper)
         // Space is valid with zero length: the encoder turns it into a word gap.
         8'h20: o_code = mk_code(3'd0, 5'b00000);
         8'h41: o_code = mk_code(3'd2, 5'b00001);
         8'h42: o_code = mk_code(3'd4, 5'b01000);
         8'h43: o_code = mk_code(3'd4, 5'b01010);
         8'h44: o_code = mk_code(3'd3, 5'b00100);
         8'h45: o_code = mk_code(3'd1, 5'b00000);
         8'h46: o_code = mk_code(3'd4, 5'b00010);
         8'h47: o_code = mk_code(3'd3, 5'b00110);
         8'h48: o_code = mk_code(3'd4, 5'b00000);
         8'h49: o_code = mk_code(3'd2, 5'b00000);
         8'h4A: o_code = mk_code(3'd4, 5'b00111);
         8'h4B: o_code = mk_code(3'd3, 5'b00101);
         8'h4C: o_code = mk_code(3'd4, 5'b00100);
         8'h4D: o_code = mk_code(3'd2, 5'b00011);
         8'h4E: o_code = mk_code(3'd2, 5'b00010);
         8'h4F: o_code = mk_code(3'd3, 5'b00111);
         8'h50: o_code = mk_code(3'd4, 5'b00110);
         8'h51: o_code = mk_code(3'd4, 5'b01101);
         8'h52: o_code = mk_code(3'd3, 5'b00010);
         8'h53: o_code = mk_code(3'd3, 5'b00000);
         8'h54: o_code = mk_code(3'd1, 5'b00001);
         8'h55: o_code = mk_code(3'd3, 5'b00001);
         8'h56: o_code = mk_code(3'd4, 5'b00001);
         8'h57: o_code = mk_code(3'd3, 5'b00011);
         8'h58: o_code = mk_code(3'd4, 5'b01001);
         8'h59: o_code = mk_code(3'd4, 5'b01011);
         8'h5A: o_code = mk_code(3'd4, 5'b01100);
         8'h30: o_code = mk_code(3'd5, 5'b11111);
         8'h31: o_code = mk_code(3'd5, 5'b01111);
         8'h32: o_code = mk_code(3'd5, 5'b00111);
         8'h33: o_code = mk_code(3'd5, 5'b00011);
         8'h34: o_code = mk_code(3'd5, 5'b00001);
         8'h35: o_code = mk_code(3'd5, 5'b00000);
         8'h36: o_code = mk_code(3'd5, 5'b10000);
         8'h37: o_code = mk_code(3'd5, 5'b11000);
         8'h38: o_code = mk_code(3'd5, 5'b11100);
         8'h39: o_code = mk_code(3'd5, 5'b11110);
         default: o_code = '0;
      endcase
   end

endmodule

// File: rtl/morse_encoder.sv
// Single-character Morse keyer: one FSM, one unit counter, one element index.
module morse_encoder
   import morse_pkg::*;
#(
   parameter int unsigned UNIT_CYCLES = 50000
) (
   input  logic       cclk,
   input  logic       rstb,
   input  logic [7:0] send_byte,
   input  logic       send_ena,
   output logic       ready,
   output logic       key,
   output logic       done,
   output logic       err
);

   localparam int unsigned CW = $clog2(WORD_GAP_UNITS * UNIT_CYCLES);
   localparam logic [CW-1:0] L_DOT  = CW'(DOT_UNITS * UNIT_CYCLES - 1);
   localparam logic [CW-1:0] L_DASH = CW'(DASH_UNITS * UNIT_CYCLES - 1);
   localparam logic [CW-1:0] L_EGAP = CW'(ELEM_GAP_UNITS * UNIT_CYCLES - 1);
   localparam logic [CW-1:0] L_CGAP = CW'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);
   localparam logic [CW-1:0] L_WGAP = CW'(WORD_GAP_UNITS * UNIT_CYCLES - 1);

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]    r_idx, w_idx_nxt;
   logic [7:0]    r_byte, w_byte_nxt;
   logic          r_key, w_key_nxt;
   logic          r_err, w_err_nxt;

   logic [7:0]    w_rom_char;
   code_t         w_code;
   logic [7:0]    w_pat_ext;
   logic [2:0]    w_elem_idx;
   logic [CW-1:0] w_elem_load;
   logic          w_cnt_zero;

   // In IDLE the ROM looks at the incoming byte; otherwise at the latched one.
   assign w_rom_char  = (r_state == S_IDLE) ? send_byte : r_byte;
   assign w_pat_ext   = {3'b000, w_code.pat};
   assign w_elem_idx  = (r_state == S_IDLE) ? (w_code.len - 3'd1) : (r_idx - 3'd1);
   assign w_elem_load = w_pat_ext[w_elem_idx] ? L_DASH : L_DOT;
   assign w_cnt_zero  = (r_cnt == '0);

   morse_code_rom u_rom (
      .i_char (w_rom_char),
      .o_code (w_code)
   );

   always_ff @(posedge cclk) begin
      if (rstb) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_byte  <= '0;
         r_key   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_byte  <= w_byte_nxt;
         r_key   <= w_key_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - CW'(1);
      w_idx_nxt   = r_idx;
      w_byte_nxt  = r_byte;
      w_key_nxt   = r_key;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (send_ena) begin
               w_byte_nxt = send_byte;
               if (!w_code.valid) begin
                  w_err_nxt = 1'b1;
               end else if (w_code.len == 3'd0) begin
                  w_state_nxt = S_WORD_GAP;
                  w_cnt_nxt   = L_WGAP;
                  w_key_nxt   = 1'b0;
               end else begin
                  w_state_nxt = S_MARK;
                  w_cnt_nxt   = w_elem_load;
                  w_idx_nxt   = w_elem_idx;
                  w_key_nxt   = 1'b1;
               end
            end
         end
         S_MARK: begin
            if (w_cnt_zero) begin
               w_key_nxt = 1'b0;
               if (r_idx == 3'd0) begin
                  w_state_nxt = S_CHAR_GAP;
                  w_cnt_nxt   = L_CGAP;
               end else begin
                  w_state_nxt = S_GAP;
                  w_cnt_nxt   = L_EGAP;
               end
            end
         end
         S_GAP: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_MARK;
               w_cnt_nxt   = w_elem_load;
               w_idx_nxt   = w_elem_idx;
               w_key_nxt   = 1'b1;
            end
         end
         S_CHAR_GAP, S_WORD_GAP: begin
            if (w_cnt_zero) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign ready = (r_state == S_IDLE) && !rstb;
   assign key   = r_key;
   assign err   = r_err;
   assign done  = r_err ||
                  (w_cnt_zero && (r_state == S_CHAR_GAP || r_state == S_WORD_GAP));

endmodule

// File: tb/tb_morse_encoder.sv
// Self-checking bench for morse_encoder with a dot/dash-string reference model.
module tb_morse_encoder;

   localparam int unsigned U = 4;

   logic       cclk = 1'b0;
   logic       rstb;
   logic [7:0] send_byte;
   logic       send_ena;
   logic       ready, key, done, err;

   int checks   = 0;
   int failures = 0;

   bit exp_q[$];
   bit exp_err;

   typedef struct {
      logic [7:0] c;
      int         exp_len;
      bit         exp_err;
   } vec_t;
   vec_t vecs[9];

   always #5 cclk = ~cclk;

   morse_encoder #(.UNIT_CYCLES(U)) dut (
      .cclk      (cclk),
      .rstb      (rstb),
      .send_byte (send_byte),
      .send_ena  (send_ena),
      .ready     (ready),
      .key       (key),
      .done      (done),
      .err       (err)
   );

   initial begin
      #600000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic string morse_str(input logic [7:0] c);
      logic [7:0] u;
      u = c;
      if (c >= "a" && c <= "z") u = c - 8'h20;
      case (u)
         " ": return " ";
         "A": return ".-";    "B": return "-...";  "C": return "-.-.";
         "D": return "-..";   "E": return ".";     "F": return "..-.";
         "G": return "--.";   "H": return "....";  "I": return "..";
         "J": return ".---";  "K": return "-.-";   "L": return ".-..";
         "M": return "--";    "N": return "-.";    "O": return "---";
         "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
         "S": return "...";   "T": return "-";     "U": return "..-";
         "V": return "...-";  "W": return ".--";   "X": return "-..-";
         "Y": return "-.--";  "Z": return "--..";
         "0": return "-----"; "1": return ".----"; "2": return "..---";
         "3": return "...--"; "4": return "....-"; "5": return ".....";
         "6": return "-...."; "7": return "--..."; "8": return "---..";
         "9": return "----.";
         default: return "";
      endcase
   endfunction

   // Expected key level for each cycle after acceptance; done falls on the last entry.
   task automatic build_model(input logic [7:0] c);
      string s;
      s = morse_str(c);
      exp_q.delete();
      exp_err = 1'b0;
      if (s == " ") begin
         repeat (4 * U) exp_q.push_back(1'b0);
      end else if (s.len() == 0) begin
         exp_q.push_back(1'b0);
         exp_err = 1'b1;
      end else begin
         for (int j = 0; j < s.len(); j++) begin
            repeat ((s[j] == "-") ? 3 * U : U) exp_q.push_back(1'b1);
            if (j != s.len() - 1) repeat (U) exp_q.push_back(1'b0);
         end
         repeat (3 * U) exp_q.push_back(1'b0);
      end
   endtask

   task automatic wait_ready(input string name);
      int w;
      w = 0;
      while (ready !== 1'b1 && w < 400) begin
         @(negedge cclk);
         w++;
      end
      chk({name, "_ready_wait"}, int'(ready), 1);
   endtask

   // Entry: at the negedge of the acceptance cycle with send_ena=1 and ready=1.
   task automatic observe(input logic [7:0] c, input int tab_len, input bit tab_err,
                          input bit use_tab, input string name);
      int  done_at, bad, derr, lim, elen;
      bit  eerr;
      build_model(c);
      elen = use_tab ? tab_len : exp_q.size();
      eerr = use_tab ? tab_err : exp_err;
      done_at = 0;
      bad     = 0;
      derr    = 0;
      lim     = elen + 8;
      @(posedge cclk);
      #1 send_ena = 1'b0;
      for (int i = 1; i <= lim && done_at == 0; i++) begin
         @(negedge cclk);
         if (i <= exp_q.size()) begin
            if (key !== exp_q[i-1]) bad++;
         end else if (key !== 1'b0) begin
            bad++;
         end
         if (done === 1'b1) begin
            done_at = i;
            derr    = int'(err);
         end else if (err !== 1'b0) begin
            bad++;
         end
      end
      chk({name, "_key_wave"}, bad, 0);
      chk({name, "_done_cycle"}, done_at, elen);
      chk({name, "_err"}, derr, int'(eerr));
      @(negedge cclk);
      chk({name, "_ready_after"}, int'(ready), 1);
      chk({name, "_done_single"}, int'(done), 0);
   endtask

   task automatic send_char(input logic [7:0] c, input int tab_len, input bit tab_err,
                            input bit use_tab, input string name);
      wait_ready(name);
      send_byte = c;
      send_ena  = 1'b1;
      observe(c, tab_len, tab_err, use_tab, name);
   endtask

   initial begin
      int         bad, n, ready_at, dones;
      logic [7:0] rc;

      rstb      = 1'b1;
      send_ena  = 1'b0;
      send_byte = 8'h00;
      repeat (3) @(negedge cclk);
      chk("rst_key", int'(key), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_ready", int'(ready), 0);
      @(posedge cclk);
      #1 rstb = 1'b0;
      @(negedge cclk);
      chk("ready_first_cycle", int'(ready), 1);

      vecs[0] = '{8'h45, 16, 1'b0};
      vecs[1] = '{8'h61, 32, 1'b0};
      vecs[2] = '{8'h30, 88, 1'b0};
      vecs[3] = '{8'h20, 16, 1'b0};
      vecs[4] = '{8'h23,  1, 1'b1};
      vecs[5] = '{8'h54, 24, 1'b0};
      vecs[6] = '{8'h53, 32, 1'b0};
      vecs[7] = '{8'h35, 48, 1'b0};
      vecs[8] = '{8'h7A, 56, 1'b0};
      for (int v = 0; v < 9; v++)
         send_char(vecs[v].c, vecs[v].exp_len, vecs[v].exp_err, 1'b1,
                   $sformatf("vec%0d", v));

      // send_ena held high with a churning send_byte while 'T' is in flight.
      wait_ready("held");
      send_byte = "T";
      send_ena  = 1'b1;
      build_model("T");
      @(posedge cclk);
      bad      = 0;
      n        = 0;
      ready_at = 0;
      while (ready_at == 0 && n < 60) begin
         @(negedge cclk);
         n++;
         if (ready === 1'b1) begin
            ready_at = n;
         end else begin
            if (n <= exp_q.size() && key !== exp_q[n-1]) bad++;
            send_byte = 8'h41 + 8'($urandom_range(25));
         end
      end
      chk("held_T_key_wave", bad, 0);
      chk("held_T_ready_cycle", ready_at, 25);
      send_byte = "E";
      observe("E", 16, 1'b0, 1'b1, "held_E");

      for (int r = 0; r < 30; r++) begin
         case ($urandom_range(4))
            0: rc = 8'h41 + 8'($urandom_range(25));
            1: rc = 8'h61 + 8'($urandom_range(25));
            2: rc = 8'h30 + 8'($urandom_range(9));
            3: rc = 8'($urandom_range(255));
            default: rc = 8'h20;
         endcase
         send_char(rc, 0, 1'b0, 1'b0, $sformatf("rnd%0d_%02h", r, rc));
      end

      // Reset pulse during the 3rd cycle of a dash.
      wait_ready("rstmid");
      send_byte = "T";
      send_ena  = 1'b1;
      @(posedge cclk);
      #1 send_ena = 1'b0;
      repeat (3) @(negedge cclk);
      chk("rstmid_key_before", int'(key), 1);
      rstb = 1'b1;
      @(posedge cclk);
      #1 rstb = 1'b0;
      @(negedge cclk);
      chk("rstmid_key_after", int'(key), 0);
      chk("rstmid_ready_after", int'(ready), 1);
      dones = int'(done);
      bad   = int'(key);
      for (int i = 0; i < 40; i++) begin
         @(negedge cclk);
         if (done === 1'b1) dones++;
         if (key !== 1'b0) bad++;
      end
      chk("rstmid_no_done", dones, 0);
      chk("rstmid_key_quiet", bad, 0);
      send_char("E", 16, 1'b0, 1'b1, "rstmid_E");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
